// File: rtl/icache_dm.sv
// icache_dm: direct-mapped, read-only instruction cache.
// A hit returns the word combinationally in the lookup cycle.
// A miss stalls fetch and refills the whole line with a sequential req/ack burst.
// Optional build macro ICACHE_STATS_EN adds hit/miss counters; otherwise they read as 0.
module icache_dm #(
   parameter int unsigned LINES = 16,
   parameter int unsigned WORDS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   output logic [31:0] instr,
   output logic        stall,
   input  logic        invalidate,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
);

   localparam int unsigned OFF_W  = $clog2(WORDS);
   localparam int unsigned IDX_W  = $clog2(LINES);
   localparam int unsigned TAG_W  = 30 - OFF_W - IDX_W;
   localparam int unsigned LINE_W = IDX_W + OFF_W;
   localparam logic [31:0] LINE_MASK = 32'(WORDS * 4 - 1);

   typedef enum logic {
      IDLE,
      REFILL
   } state_t;

   state_t state;
   state_t next_state;

   logic [OFF_W-1:0]       off;
   logic [IDX_W-1:0]       idx;
   logic [TAG_W-1:0]       tag;

   logic [LINES-1:0]       valid;
   logic [TAG_W-1:0]       tag_mem  [LINES];
   logic [31:0]            data_mem [LINES*WORDS];

   // Tag and index of the line being refilled, captured when the miss is detected.
   logic [TAG_W+IDX_W-1:0] base_q;
   logic [IDX_W-1:0]       r_idx;
   logic [TAG_W-1:0]       r_tag;
   logic [OFF_W-1:0]       word_cnt;

   logic                   hit;
   logic                   start_refill;
   logic                   fill_we;
   logic                   last_ack;

   assign off   = pc[OFF_W+1:2];
   assign idx   = pc[LINE_W+1:OFF_W+2];
   assign tag   = pc[31:LINE_W+2];

   assign r_idx = base_q[IDX_W-1:0];
   assign r_tag = base_q[TAG_W+IDX_W-1:IDX_W];

   assign hit          = valid[idx] && (tag_mem[idx] == tag) && (state == IDLE);
   assign start_refill = (state == IDLE) && !hit && !invalidate;
   assign fill_we      = (state == REFILL) && mem_ack;
   assign last_ack     = fill_we && (word_cnt == OFF_W'(WORDS - 1));

   assign instr = data_mem[{idx, off}];

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and stall decode.
   always_comb begin
      next_state = state;
      stall      = 1'b1;
      case (state)
         IDLE: begin
            stall = ~hit;
            if (start_refill) begin
               next_state = REFILL;
            end
         end
         REFILL: begin
            if (last_ack) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Refill sequencing: latched line base, word counter and registered bus request.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         base_q   <= '0;
         word_cnt <= '0;
         mem_req  <= 1'b0;
         mem_addr <= '0;
      end else if (start_refill) begin
         base_q   <= {tag, idx};
         word_cnt <= '0;
         mem_req  <= 1'b1;
         mem_addr <= pc & ~LINE_MASK;
      end else if (fill_we) begin
         word_cnt <= word_cnt + OFF_W'(1);
         if (last_ack) begin
            mem_req  <= 1'b0;
            mem_addr <= '0;
         end else begin
            mem_addr <= mem_addr + 32'd4;
         end
      end
   end

   // Valid bits: invalidate takes priority over the completing refill.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid <= '0;
      end else if (invalidate) begin
         valid <= '0;
      end else if (last_ack) begin
         valid[r_idx] <= 1'b1;
      end
   end

   // Tag and data arrays, written only by the refill and never reset.
   always_ff @(posedge clk) begin
      if (fill_we) begin
         data_mem[{r_idx, word_cnt}] <= mem_rdata;
      end
      if (last_ack) begin
         tag_mem[r_idx] <= r_tag;
      end
   end

`ifdef ICACHE_STATS_EN
   logic [31:0] hit_q;
   logic [31:0] miss_q;

   // Hit and miss statistics, wrapping modulo 2^32.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hit_q  <= '0;
         miss_q <= '0;
      end else begin
         if (hit) begin
            hit_q <= hit_q + 32'd1;
         end
         if (start_refill) begin
            miss_q <= miss_q + 32'd1;
         end
      end
   end

   assign hit_count  = hit_q;
   assign miss_count = miss_q;
`else
   assign hit_count  = '0;
   assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Directed self-checking bench for icache_dm (LINES=16, WORDS=4).
module tb_icache_dm;

   localparam int WORDS = 4;
`ifdef ICACHE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic [31:0] instr;
   logic        stall;
   logic        invalidate;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   int passed = 0;
   int fails  = 0;
   int total  = 0;
   int stalls;
   int reqs;

   icache_dm #(.LINES(16), .WORDS(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .pc         (pc),
      .instr      (instr),
      .stall      (stall),
      .invalidate (invalidate),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   always #5 clk = ~clk;

   // Instruction memory contents as a fixed function of the word address.
   function automatic logic [31:0] fmem(input logic [31:0] a);
      return (a * 32'd2654435761) ^ 32'h1357_9BDF;
   endfunction

   assign mem_rdata = fmem(mem_addr);

   function automatic logic [31:0] stat(input logic [31:0] n);
      return STATS ? n : 32'd0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Entered just after a negedge with a missing pc applied; acks every
   // 'period'-th request cycle and returns once WORDS acks have been taken.
   task automatic refill(input logic [31:0] base, input int period, input bit inv_last,
                         output int n_stall, output int n_req);
      int acks;
      acks    = 0;
      n_stall = 0;
      n_req   = 0;
      while (acks < WORDS && n_stall < 200) begin
         if (stall === 1'b1) n_stall++;
         if (mem_req === 1'b1) begin
            chk("refill_addr", mem_addr, base + 32'(4 * acks));
            n_req++;
            if (n_req % period == 0) begin
               mem_ack = 1'b1;
               acks++;
               if (inv_last && acks == WORDS) invalidate = 1'b1;
            end
         end
         @(negedge clk);
         mem_ack    = 1'b0;
         invalidate = 1'b0;
         #1;
      end
      chk("refill_bound", 32'(acks), 32'(WORDS));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b0;
      pc         = 32'h0;
      invalidate = 1'b0;
      mem_ack    = 1'b0;
      #12;
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_stall", {31'd0, stall}, 32'd1);
      chk("rst_hit_count", hit_count, 32'd0);
      chk("rst_miss_count", miss_count, 32'd0);

      // Cold miss at 0x40.
      @(negedge clk);
      reset = 1'b1;
      pc    = 32'h40;
      #1;
      chk("cold_stall", {31'd0, stall}, 32'd1);
      chk("cold_req_idle", {31'd0, mem_req}, 32'd0);
      refill(32'h40, 1, 1'b0, stalls, reqs);
      chk("cold_stall_cycles", 32'(stalls), 32'd5);
      chk("cold_req_cycles", 32'(reqs), 32'd4);
      chk("cold_hit_stall", {31'd0, stall}, 32'd0);
      chk("cold_instr", instr, fmem(32'h40));
      chk("cold_addr_idle", mem_addr, 32'h0);
      chk("cold_miss_count", miss_count, stat(32'd1));

      // Hits on the rest of the line.
      @(negedge clk); pc = 32'h44; #1;
      chk("hit44_stall", {31'd0, stall}, 32'd0);
      chk("hit44_instr", instr, fmem(32'h44));
      @(negedge clk); pc = 32'h48; #1;
      chk("hit48_stall", {31'd0, stall}, 32'd0);
      chk("hit48_instr", instr, fmem(32'h48));
      @(negedge clk); pc = 32'h4C; #1;
      chk("hit4c_stall", {31'd0, stall}, 32'd0);
      chk("hit4c_instr", instr, fmem(32'h4C));

      // Conflict eviction: 0x440 maps to the same index as 0x40.
      @(negedge clk); pc = 32'h440; #1;
      chk("hit_count4", hit_count, stat(32'd4));
      chk("conf_stall", {31'd0, stall}, 32'd1);
      refill(32'h440, 1, 1'b0, stalls, reqs);
      chk("conf_stall_cycles", 32'(stalls), 32'd5);
      chk("conf_instr", instr, fmem(32'h440));
      pc = 32'h40; #1;
      chk("evict_stall", {31'd0, stall}, 32'd1);
      refill(32'h40, 1, 1'b0, stalls, reqs);
      chk("evict_instr", instr, fmem(32'h40));
      chk("evict_miss_count", miss_count, stat(32'd3));

      // Wait states: ack every 3rd request cycle.
      pc = 32'h108; #1;
      chk("wait_stall", {31'd0, stall}, 32'd1);
      refill(32'h100, 3, 1'b0, stalls, reqs);
      chk("wait_stall_cycles", 32'(stalls), 32'd13);
      chk("wait_req_cycles", 32'(reqs), 32'd12);
      chk("wait_instr", instr, fmem(32'h108));

      // Invalidate coincident with the final ack leaves the line invalid.
      pc = 32'h80; #1;
      refill(32'h80, 1, 1'b1, stalls, reqs);
      chk("invfin_line_invalid", {31'd0, stall}, 32'd1);
      pc = 32'h40; #1;
      chk("invfin_40_miss", {31'd0, stall}, 32'd1);
      refill(32'h40, 1, 1'b0, stalls, reqs);
      chk("invfin_stall_cycles", 32'(stalls), 32'd5);
      chk("invfin_instr", instr, fmem(32'h40));

      // Invalidate in IDLE after a fill: the current lookup still hits, the next misses.
      @(negedge clk); invalidate = 1'b1; #1;
      chk("invidle_hit", {31'd0, stall}, 32'd0);
      @(negedge clk); invalidate = 1'b0; #1;
      chk("invidle_miss", {31'd0, stall}, 32'd1);
      refill(32'h40, 1, 1'b0, stalls, reqs);
      chk("invidle_stall_cycles", 32'(stalls), 32'd5);

      // Reset after the 2nd ack of a refill.
      pc = 32'h144; #1;
      chk("mid_stall", {31'd0, stall}, 32'd1);
      @(negedge clk); #1;
      chk("mid_addr0", mem_addr, 32'h140);
      mem_ack = 1'b1;
      @(negedge clk); #1;
      chk("mid_addr1", mem_addr, 32'h144);
      @(negedge clk); mem_ack = 1'b0; #1;
      chk("mid_req_before", {31'd0, mem_req}, 32'd1);
      reset = 1'b0; #1;
      chk("mid_req_reset", {31'd0, mem_req}, 32'd0);
      chk("mid_addr_reset", mem_addr, 32'h0);
      chk("mid_miss_cleared", miss_count, 32'd0);
      @(negedge clk); reset = 1'b1; pc = 32'h40; #1;
      chk("post_rst_miss", {31'd0, stall}, 32'd1);
      refill(32'h40, 1, 1'b0, stalls, reqs);
      chk("post_rst_stall_cycles", 32'(stalls), 32'd5);
      chk("post_rst_instr", instr, fmem(32'h40));
      chk("post_rst_miss_count", miss_count, stat(32'd1));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the pipelined datapath fetch stage and a word-wide instruction memory bus.
- Takes the fetch PC and returns the instruction word on a hit in the same cycle.
- On a miss, raises a stall for the hazard unit and refills the whole line with a sequential word-by-word req/ack burst.

Parameters:
- LINES, 16, number of cache lines (power of two, >=2)
- WORDS, 4, 32-bit words per line (power of two, >=2)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- pc  in  32  fetch address; bits [1:0] ignored
- instr  out  32  instruction word for pc, valid when stall=0
- stall  out  1  fetch must hold; feeds the hazard unit's stallF/stallD
- invalidate  in  1  single-cycle pulse that clears all valid bits
- mem_req  out  1  refill request, held until the last word is acked
- mem_addr  out  32  word-aligned refill address
- mem_ack  in  1  mem_rdata is valid this cycle
- mem_rdata  in  32  refill data word
- hit_count  out  32  hit counter (see Optional Feature)
- miss_count  out  32  miss counter (see Optional Feature)

Behaviour:
- Address split:
  - offset = pc[log2(WORDS)+1:2]
  - index = next log2(LINES) bits
  - tag = remaining upper bits
- Storage: per-line valid bit (flops), tag array, data array (LINES*WORDS words). Reads are combinational.
- hit = valid[index] & (tag_array[index]==tag) & (state==IDLE).
- instr = data[index][offset]; value is don't-care when stall=1.
- FSM states: IDLE, REFILL.
  - IDLE: stall = ~hit. On a miss (and no invalidate that cycle), latch the line base address (pc with offset and byte bits zeroed), clear the word counter, go to REFILL next edge.
  - REFILL: stall=1, mem_req=1, mem_addr = line_base + 4*word_cnt.
    - Each edge with mem_ack=1: write mem_rdata into data[latched index][word_cnt], then increment word_cnt.
    - On the ack with word_cnt==WORDS-1: write the tag, set valid, clear mem_req, return to IDLE.
    - mem_ack outside REFILL is ignored.
- Latency:
  - A hit gives 0 stall cycles.
  - A miss with zero-wait memory (ack every REFILL cycle) stalls for WORDS+1 cycles: the detect cycle plus WORDS refill cycles. The following IDLE cycle hits.
  - Each memory wait cycle adds one stall cycle.
- pc must stay stable while stall=1. The refill uses only the latched base address, so pc changes during REFILL cannot corrupt it.
- mem_addr and mem_req are registered and change only at edges. mem_addr is 0 in IDLE.
- invalidate:
  - Clears all valid bits at the next edge, in any state.
  - In IDLE, a coincident miss does not start a refill that cycle; the lookup retries next cycle.
  - In REFILL, the refill runs to completion, but if invalidate coincides with the final ack, the refilled line is left invalid (invalidate wins).
- Reset (asynchronous, active-low), immediate on assertion:
  - state=IDLE, all valid bits 0, word_cnt=0
  - mem_req=0, mem_addr=0, counters=0
  - Outputs after reset: stall=1 (every lookup misses); instr don't-care.
  - Reset mid-refill abandons the burst; the memory side shares the reset and drops its transaction.
- Tag and data arrays are not reset.

Optional Feature:
- Macro ICACHE_STATS_EN.
- Defined:
  - hit_count increments on each IDLE cycle with hit=1.
  - miss_count increments on each IDLE-to-REFILL transition.
  - Both wrap modulo 2^32 and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- Cold miss (LINES=16, WORDS=4, ack every cycle): reset then pc=0x00000040.
  - Required: stall=1 for 5 cycles; mem_addr sequence 0x40,0x44,0x48,0x4C; then stall=0 and instr = word 0 of the burst.
  - With ICACHE_STATS_EN: miss_count=1.
- Line hits: after the cold miss, pc=0x44, 0x48, 0x4C on consecutive cycles.
  - Required: stall=0 each cycle, instr equals the 2nd, 3rd and 4th burst words.
  - With ICACHE_STATS_EN: hit_count=4 after the 4th hit.
- Conflict eviction: fill 0x00000040, then access 0x00000440 (same index, different tag).
  - Required: miss and refill from 0x440.
  - Then pc=0x40 misses again and the refill restarts at 0x40.
- Wait states: ack asserted every 3rd cycle during refill.
  - Required: mem_addr advances only after each ack, mem_req stays high for 12 cycles, stall lasts 13 cycles.
- Invalidate races:
  - Pulse invalidate on the final ack cycle; then pc=0x40. Required: stall=1 and a new refill.
  - Pulse invalidate in IDLE after a fill. Required: the next lookup misses.
- Reset mid-refill: assert reset after the 2nd ack.
  - Required: mem_req=0 immediately; after release, pc=0x40 misses and refills from 0x40 (no partial-line hit).
